inert_seq: RTL and testbench
============================

# inert_seq

SPI transaction sequencer for the iNEMO inertial sensor, used inside the inertial interface.
- After reset it waits a power-up interval, then issues three configuration writes through the SPI monarch.
- It then services each sensor data-ready interrupt by reading yaw-rate low and high bytes.
- It presents the 16-bit signed yaw rate with a one-cycle valid pulse to the inertial integrator.

## Interface
Parameters:
- FAST_SIM, 1, shortens the power-up wait to 512 clocks (0: 65536 clocks)

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- INT  input  1  sensor data-ready interrupt, asynchronous, active-high level
- done  input  1  SPI monarch transaction complete, 1-cycle pulse
- resp  input  16  SPI monarch response word; valid in the `done` cycle
- wrt  output  1  start SPI transaction, 1-cycle pulse
- cmd  output  16  SPI command word to monarch
- yaw_rt  output  16  signed yaw rate {yawH, yawL}
- vld  output  1  yaw_rt updated, 1-cycle pulse
- init_done  output  1  configuration complete, sticky high until reset

## Operation
- INT passes through a 2-flop synchronizer (INT_ff2) before use. The trigger is level-sensitive, with no edge detect.
- A 16-bit power-up timer counts from reset. Wait ends at count 511 (FAST_SIM=1) or 65535 (FAST_SIM=0).
- States:
  - INIT_WAIT: timer running. On terminal count -> CFG1.
  - CFG1: cmd=0x0D02 (enable INT on gyro data-ready); wait done -> CFG2.
  - CFG2: cmd=0x1160 (gyro ODR 416 Hz, 250 dps); wait done -> CFG3.
  - CFG3: cmd=0x1440 (rounding on); wait done -> IDLE, set init_done.
  - IDLE: if INT_ff2 -> RDL.
  - RDL: cmd=0xA600 (read yawL); on done capture resp[7:0] into yawL -> RDH.
  - RDH: cmd=0xA700 (read yawH); on done load yaw_rt={resp[7:0],yawL} -> VLD.
  - VLD: assert vld -> IDLE.
- wrt pulses high for exactly one cycle on the first cycle of each CFGx/RDL/RDH state. It never re-fires inside the same state.
- cmd is registered and holds from the wrt cycle until the state changes.
- yaw_rt holds its last value between updates. It is never partially updated: yawL is held in a separate register.
- done arriving in IDLE, INIT_WAIT or VLD is ignored.
- INT_ff2 high during INIT_WAIT or CFGx is ignored. If it is still high on IDLE entry, a read starts immediately.

## Timing
- Reset values: wrt=0, cmd=0x0000, yaw_rt=0x0000, vld=0, init_done=0, state=INIT_WAIT, timer=0.
- First wrt occurs on the cycle after the timer reaches terminal count, i.e. 513 clocks after reset release with FAST_SIM=1.
- Config transitions:
  - next state is registered on the done cycle;
  - the next wrt comes 1 cycle after done;
  - init_done rises on the cycle after the CFG3 done.
- Read transitions:
  - INT rising to RDL entry takes 3 clocks (2 sync + 1 state);
  - wrt is asserted on RDL entry;
  - the RDH wrt comes 1 cycle after the RDL done;
  - yaw_rt updates on the cycle after the RDH done, with vld high in that same cycle for exactly one clock.
- Back-to-back interrupts: the earliest next RDL entry is the cycle after VLD.
- Asynchronous reset mid-transaction (any state) returns all outputs to reset values immediately. The full power-up wait and configuration then repeat. Any in-flight SPI transaction is abandoned; a late done after reset is ignored in INIT_WAIT.

## Test plan
- Reset/config: release rst_n with FAST_SIM=1 and a monarch model returning done 40 clocks after each wrt.
  - Expect wrt at cycle 513, 554 and 595, with cmd 0x0D02, 0x1160 and 0x1440.
  - Expect init_done high at cycle 636.
- Single read: after init, raise INT; the model returns resp=0x00F4 then 0x00FF.
  - Expect cmd 0xA600, then 0xA700.
  - Expect yaw_rt=0xFFF4 (-12) with a one-cycle vld 1 cycle after the second done.
- INT during config: hold INT high from cycle 0.
  - Expect no 0xA600 command before init_done.
  - Expect RDL entered on the first IDLE cycle.
- Stuck INT: hold INT high through three read pairs.
  - Expect three consecutive RDL/RDH pairs.
  - Expect one vld per pair, each separated by exactly one VLD cycle.
- Spurious done: pulse done while in IDLE.
  - Expect no state change, no wrt and no vld; yaw_rt unchanged.
- Reset mid-read: assert rst_n low between the RDL done and the RDH done.
  - Expect yaw_rt=0, vld=0, init_done=0 immediately.
  - Expect the full 513-cycle wait, then 0x0D02 reissued.

Source files
------------

// File: rtl/inert_seq.sv
// inert_seq: SPI transaction sequencer for the iNEMO inertial sensor.
// After reset it waits out the sensor power-up interval, writes three
// configuration registers, then answers each data-ready interrupt by reading
// the yaw-rate low and high bytes and presenting the signed 16-bit result with
// a one-cycle valid pulse.
module inert_seq #(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] resp,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        init_done
);

  typedef enum logic [2:0] {
    StInitWait,
    StCfg1,
    StCfg2,
    StCfg3,
    StIdle,
    StRdl,
    StRdh,
    StVld
  } state_e;

  // Last timer value of the power-up wait; the transition fires on the cycle
  // after the timer shows this value.
  localparam logic [15:0] TimerTerm = FAST_SIM ? 16'd511 : 16'hFFFF;

  // Sensor register accesses: bit 15 set marks a read.
  localparam logic [15:0] CmdCfgInt  = 16'h0D02;  // INT1 on gyro data-ready
  localparam logic [15:0] CmdCfgOdr  = 16'h1160;  // gyro 416 Hz, 250 dps
  localparam logic [15:0] CmdCfgRnd  = 16'h1440;  // output rounding on
  localparam logic [15:0] CmdRdYawL  = 16'hA600;
  localparam logic [15:0] CmdRdYawH  = 16'hA700;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        wrt_q, wrt_d;
  logic [15:0] cmd_q, cmd_d;
  logic [7:0]  yaw_l_q, yaw_l_d;
  logic [15:0] yaw_rt_q, yaw_rt_d;
  logic        vld_q, vld_d;
  logic        init_done_q, init_done_d;
  logic        int_ff1_q, int_ff2_q;

  // Only the low byte of each SPI response carries register data.
  logic unused_resp_hi;
  assign unused_resp_hi = ^resp[15:8];

  // Two-flop synchronizer for the asynchronous interrupt level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ff1_q <= 1'b0;
      int_ff2_q <= 1'b0;
    end else begin
      int_ff1_q <= INT;
      int_ff2_q <= int_ff1_q;
    end
  end

  // Next-state and registered-output decode. wrt is raised only on the
  // transition into a transaction state, so it can never re-fire while the
  // sequencer waits inside that state.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    wrt_d       = 1'b0;
    cmd_d       = cmd_q;
    yaw_l_d     = yaw_l_q;
    yaw_rt_d    = yaw_rt_q;
    vld_d       = 1'b0;
    init_done_d = init_done_q;

    unique case (state_q)
      StInitWait: begin
        // Interrupts and stray done pulses are ignored until configured.
        if (timer_q == TimerTerm) begin
          state_d = StCfg1;
          wrt_d   = 1'b1;
          cmd_d   = CmdCfgInt;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      StCfg1: begin
        if (done) begin
          state_d = StCfg2;
          wrt_d   = 1'b1;
          cmd_d   = CmdCfgOdr;
        end
      end

      StCfg2: begin
        if (done) begin
          state_d = StCfg3;
          wrt_d   = 1'b1;
          cmd_d   = CmdCfgRnd;
        end
      end

      StCfg3: begin
        if (done) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end
      end

      StIdle: begin
        // Level trigger: an interrupt held through configuration starts a read
        // on the first idle cycle.
        if (int_ff2_q) begin
          state_d = StRdl;
          wrt_d   = 1'b1;
          cmd_d   = CmdRdYawL;
        end
      end

      StRdl: begin
        if (done) begin
          yaw_l_d = resp[7:0];
          state_d = StRdh;
          wrt_d   = 1'b1;
          cmd_d   = CmdRdYawH;
        end
      end

      StRdh: begin
        // Both bytes land in yaw_rt together so the integrator never sees a
        // half-updated sample.
        if (done) begin
          yaw_rt_d = {resp[7:0], yaw_l_q};
          vld_d    = 1'b1;
          state_d  = StVld;
        end
      end

      StVld: begin
        // A still-asserted interrupt chains straight into the next read.
        if (int_ff2_q) begin
          state_d = StRdl;
          wrt_d   = 1'b1;
          cmd_d   = CmdRdYawL;
        end else begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StInitWait;
        timer_d = 16'd0;
      end
    endcase
  end

  // Sequencer state, power-up timer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInitWait;
      timer_q     <= 16'd0;
      wrt_q       <= 1'b0;
      cmd_q       <= 16'd0;
      yaw_l_q     <= 8'd0;
      yaw_rt_q    <= 16'd0;
      vld_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      wrt_q       <= wrt_d;
      cmd_q       <= cmd_d;
      yaw_l_q     <= yaw_l_d;
      yaw_rt_q    <= yaw_rt_d;
      vld_q       <= vld_d;
      init_done_q <= init_done_d;
    end
  end

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign yaw_rt    = yaw_rt_q;
  assign vld       = vld_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_inert_seq.sv
// tb_inert_seq: directed bench for inert_seq with a simple SPI monarch model
// that answers every wrt with done 40 clocks later. Cycle numbers count clock
// periods after reset release, starting at 1.
module tb_inert_seq;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic        int_s    = 1'b0;
  logic        done     = 1'b0;
  logic        spur_req = 1'b0;
  logic [15:0] resp     = 16'h0000;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] yaw_rt;
  logic        vld;
  logic        init_done;

  int          cyc = 1;
  int          mon_cnt = 0;
  logic [15:0] mon_resp = 16'h0000;
  logic [7:0]  src_l = 8'h00;
  logic [7:0]  src_h = 8'h00;

  int          wrt_cyc[256];
  logic [15:0] wrt_cmd[256];
  int          vld_cyc[256];
  logic [15:0] vld_val[256];
  int          wn = 0;
  int          vn = 0;
  int          init_cyc = 0;
  int          wrt_dup = 0;
  int          vld_dup = 0;
  logic        wrt_prev = 1'b0;
  logic        vld_prev = 1'b0;
  logic        init_prev = 1'b0;

  int          n_checks = 0;
  int          n_errors = 0;

  inert_seq #(
    .FAST_SIM (1'b1)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .INT       (int_s),
    .done      (done),
    .resp      (resp),
    .wrt       (wrt),
    .cmd       (cmd),
    .yaw_rt    (yaw_rt),
    .vld       (vld),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  // Period counter: 1 during reset and the first period after release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 1;
    else        cyc <= cyc + 1;
  end

  // SPI monarch: done 40 cycles after wrt; it keeps counting through reset so
  // an abandoned transaction produces a late done.
  always @(negedge clk) begin
    done <= spur_req;
    if (mon_cnt > 1) begin
      mon_cnt <= mon_cnt - 1;
    end else if (mon_cnt == 1) begin
      mon_cnt <= 0;
      done    <= 1'b1;
      resp    <= mon_resp;
    end
    if (wrt) begin
      mon_cnt <= 40;
      if (cmd == 16'hA600)      mon_resp <= {8'h00, src_l};
      else if (cmd == 16'hA700) mon_resp <= {8'h00, src_h};
      else                      mon_resp <= 16'h0000;
    end
  end

  // Event log of wrt/vld pulses and init_done rises.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wrt && wn < 256) begin
        wrt_cyc[wn] <= cyc;
        wrt_cmd[wn] <= cmd;
        wn          <= wn + 1;
      end
      if (vld && vn < 256) begin
        vld_cyc[vn] <= cyc;
        vld_val[vn] <= yaw_rt;
        vn          <= vn + 1;
      end
      if (wrt && wrt_prev) wrt_dup <= wrt_dup + 1;
      if (vld && vld_prev) vld_dup <= vld_dup + 1;
      if (init_done && !init_prev) init_cyc <= cyc;
    end
    wrt_prev  <= wrt;
    vld_prev  <= vld;
    init_prev <= init_done;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", tag, got, got, exp, exp);
    end
  endtask

  // Advance to the negedge of the given cycle (bounded).
  task automatic wait_until(input int target);
    for (int i = 0; i < 4000; i++) begin
      if (cyc >= target) break;
      @(negedge clk);
    end
  endtask

  // Check logged wrt number idx against expected cycle and command.
  task automatic check_wrt(input string tag, input int idx, input int exp_cyc,
                           input logic [15:0] exp_cmd);
    check({tag, "_cyc"}, wrt_cyc[idx], exp_cyc);
    check({tag, "_cmd"}, {16'h0, wrt_cmd[idx]}, {16'h0, exp_cmd});
  endtask

  initial begin
    int t;
    int wb;
    int vb;

    // Reset values
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wrt", {31'h0, wrt}, 32'h0);
    check("rst_cmd", {16'h0, cmd}, 32'h0);
    check("rst_yaw", {16'h0, yaw_rt}, 32'h0);
    check("rst_vld", {31'h0, vld}, 32'h0);
    check("rst_init", {31'h0, init_done}, 32'h0);
    rst_n = 1'b1;

    // Power-up wait and configuration
    wait_until(530);
    check("cfg1_hold_cmd", {16'h0, cmd}, 32'h0D02);
    check("cfg1_hold_wrt", {31'h0, wrt}, 32'h0);
    wait_until(700);
    check("cfg_nwrt", wn, 3);
    check_wrt("cfg1", 0, 513, 16'h0D02);
    check_wrt("cfg2", 1, 554, 16'h1160);
    check_wrt("cfg3", 2, 595, 16'h1440);
    check("init_rise", init_cyc, 636);
    check("init_high", {31'h0, init_done}, 32'h1);

    // Single read: 0xFFF4 = -12
    src_l = 8'hF4;
    src_h = 8'hFF;
    wb    = wn;
    vb    = vn;
    t     = cyc;
    int_s = 1'b1;
    wait_until(t + 3);
    int_s = 1'b0;
    wait_until(t + 100);
    check_wrt("rd_l", wb, t + 3, 16'hA600);
    check_wrt("rd_h", wb + 1, t + 44, 16'hA700);
    check("rd_nwrt", wn, wb + 2);
    check("rd_vld_cyc", vld_cyc[vb], t + 85);
    check("rd_vld_val", {16'h0, vld_val[vb]}, 32'hFFF4);
    check("rd_nvld", vn, vb + 1);
    check("rd_hold", {16'h0, yaw_rt}, 32'hFFF4);

    // Spurious done while idle
    wb = wn;
    vb = vn;
    @(posedge clk);
    #1 spur_req = 1'b1;
    @(posedge clk);
    #1 spur_req = 1'b0;
    repeat (6) @(negedge clk);
    check("spur_nwrt", wn, wb);
    check("spur_nvld", vn, vb);
    check("spur_yaw", {16'h0, yaw_rt}, 32'hFFF4);

    // Stuck interrupt: three chained read pairs
    src_l = 8'h34;
    src_h = 8'h12;
    wb    = wn;
    vb    = vn;
    t     = cyc;
    int_s = 1'b1;
    wait_until(t + 60);
    src_l = 8'h80;
    src_h = 8'h7F;
    wait_until(t + 140);
    src_l = 8'h01;
    src_h = 8'h80;
    wait_until(t + 200);
    int_s = 1'b0;
    wait_until(t + 300);
    check_wrt("stk1_l", wb,     t + 3,   16'hA600);
    check_wrt("stk1_h", wb + 1, t + 44,  16'hA700);
    check_wrt("stk2_l", wb + 2, t + 86,  16'hA600);
    check_wrt("stk2_h", wb + 3, t + 127, 16'hA700);
    check_wrt("stk3_l", wb + 4, t + 169, 16'hA600);
    check_wrt("stk3_h", wb + 5, t + 210, 16'hA700);
    check("stk_nwrt", wn, wb + 6);
    check("stk_v1_cyc", vld_cyc[vb], t + 85);
    check("stk_v1_val", {16'h0, vld_val[vb]}, 32'h1234);
    check("stk_v2_cyc", vld_cyc[vb + 1], t + 168);
    check("stk_v2_val", {16'h0, vld_val[vb + 1]}, 32'h7F80);
    check("stk_v3_cyc", vld_cyc[vb + 2], t + 251);
    check("stk_v3_val", {16'h0, vld_val[vb + 2]}, 32'h8001);
    check("stk_nvld", vn, vb + 3);

    // Reset between RDL done (t+43) and RDH done (t+84)
    t     = cyc;
    int_s = 1'b1;
    wait_until(t + 3);
    int_s = 1'b0;
    wait_until(t + 60);
    rst_n = 1'b0;
    #1;
    check("mid_yaw", {16'h0, yaw_rt}, 32'h0);
    check("mid_vld", {31'h0, vld}, 32'h0);
    check("mid_init", {31'h0, init_done}, 32'h0);
    check("mid_wrt", {31'h0, wrt}, 32'h0);
    check("mid_cmd", {16'h0, cmd}, 32'h0);
    wb = wn;
    vb = vn;
    repeat (2) @(negedge clk);
    // Interrupt held high through the whole re-initialisation
    rst_n = 1'b1;
    int_s = 1'b1;
    wait_until(500);
    check("re_wait_nwrt", wn, wb);
    check("re_wait_yaw", {16'h0, yaw_rt}, 32'h0);
    wait_until(635);
    check("re_init_lo", {31'h0, init_done}, 32'h0);
    wait_until(636);
    check("re_init_hi", {31'h0, init_done}, 32'h1);
    check("re_nwrt_cfg", wn, wb + 3);
    wait_until(640);
    int_s = 1'b0;
    wait_until(760);
    check_wrt("re_cfg1", wb,     513, 16'h0D02);
    check_wrt("re_cfg2", wb + 1, 554, 16'h1160);
    check_wrt("re_cfg3", wb + 2, 595, 16'h1440);
    check_wrt("re_rd_l", wb + 3, 637, 16'hA600);
    check_wrt("re_rd_h", wb + 4, 678, 16'hA700);
    check("re_nwrt", wn, wb + 5);
    check("re_vld_cyc", vld_cyc[vb], 719);
    check("re_vld_val", {16'h0, vld_val[vb]}, 32'h8001);
    check("re_nvld", vn, vb + 1);

    check("wrt_one_cycle", wrt_dup, 0);
    check("vld_one_cycle", vld_dup, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
